fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 26 ++
 rtl/fetch_stage_if.sv | 19 +
 rtl/fetch_skid_buffer.sv | 44 ++++
 rtl/fetch_stage.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - pipeline slot status types and shared fetch constants
package pipeline_status;
  typedef enum logic [1:0] {
    BUBBLE           = 2'd0,
    VALID            = 2'd1,
    FETCH_MISALIGNED = 2'd2,
    FETCH_FAULT      = 2'd3
  } forwards_t;

  typedef enum logic [1:0] {
    READY = 2'd0,
    STALL = 2'd1,
    JUMP  = 2'd2
  } backwards_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    forwards_t   status;
  } fetch_entry_t;
endpackage

package constants;
  localparam logic [31:0] RESET_ADDRESS = 32'h0000_0000;
  localparam logic [31:0] NOP           = 32'h0000_0013;
endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction fetch bus between fetch stage (master) and memory (slave)
interface fetch_stage_if;
  logic        wb_cyc_out;
  logic        wb_stb_out;
  logic [31:0] wb_adr_out;
  logic [31:0] wb_dat_in;
  logic        wb_ack_in;
  logic        wb_err_in;

  modport master (
    output wb_cyc_out, wb_stb_out, wb_adr_out,
    input  wb_dat_in, wb_ack_in, wb_err_in
  );

  modport slave (
    input  wb_cyc_out, wb_stb_out, wb_adr_out,
    output wb_dat_in, wb_ack_in, wb_err_in
  );
endinterface

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry holding slot for a fetch result that arrived during a stall
module fetch_skid_buffer
  import pipeline_status::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t entry_i,
  output logic         valid_o,
  output fetch_entry_t entry_o
);

  logic         valid_q, valid_d;
  fetch_entry_t entry_q, entry_d;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (push_i) begin
      valid_d = 1'b1;
      entry_d = entry_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with skid buffer, redirect squash and fault halt
// Optional FETCH_MISALIGN_CHECK_EN: report misaligned fetch_pc instead of forcing alignment.
module fetch_stage
  import pipeline_status::*;
  import constants::*;
(
  input  logic        clk,
  input  logic        rst,
  fetch_stage_if.master wb,
  output logic [31:0] instruction_reg_out,
  output logic [31:0] program_counter_reg_out,
  output forwards_t   status_forwards_out,
  input  backwards_t  status_backwards_in,
  input  logic [31:0] jump_address_backwards_in
);

  typedef enum logic [1:0] {FETCH, SQUASH, HOLD, HALTED} state_t;

  state_t       state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  squash_adr_q, squash_adr_d;
  fetch_entry_t out_q, out_d;

  logic         misaligned;
  logic [31:0]  jump_target;
  logic [31:0]  adr_raw;
  logic         bus_req, bus_done, fetching, ack_fetch, err_fetch;
  logic         entry_valid;
  fetch_entry_t entry, bubble_entry;
  logic         skid_push, skid_pop, skid_clear, skid_valid;
  fetch_entry_t skid_entry;

  // SQUASH keeps presenting the abandoned address until the bus answers it
  assign adr_raw = (state_q == SQUASH) ? squash_adr_q : fetch_pc_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned    = (fetch_pc_q[1:0] != 2'b00);
  assign jump_target   = jump_address_backwards_in;
  assign wb.wb_adr_out = adr_raw;
`else
  assign misaligned    = 1'b0;
  assign jump_target   = jump_address_backwards_in & 32'hFFFF_FFFC;
  assign wb.wb_adr_out = adr_raw & 32'hFFFF_FFFC;
`endif

  assign fetching  = (state_q == FETCH) && !misaligned;
  assign bus_req   = fetching || (state_q == SQUASH);
  assign bus_done  = wb.wb_ack_in || wb.wb_err_in;
  assign ack_fetch = fetching && wb.wb_ack_in;
  assign err_fetch = fetching && !wb.wb_ack_in && wb.wb_err_in;

  assign wb.wb_cyc_out = bus_req && !rst;
  assign wb.wb_stb_out = bus_req && !rst;

  assign entry_valid = ack_fetch || err_fetch || ((state_q == FETCH) && misaligned);

  always_comb begin
    entry.pc = fetch_pc_q;
    if (ack_fetch) begin
      entry.instr  = wb.wb_dat_in;
      entry.status = VALID;
    end else if (err_fetch) begin
      entry.instr  = NOP;
      entry.status = FETCH_FAULT;
    end else begin
      entry.instr  = NOP;
      entry.status = FETCH_MISALIGNED;
    end
  end

  assign bubble_entry = '{instr: NOP, pc: out_q.pc, status: BUBBLE};

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    squash_adr_d = squash_adr_q;
    out_d        = out_q;
    skid_push    = 1'b0;
    skid_pop     = 1'b0;
    skid_clear   = 1'b0;

    case (status_backwards_in)
      JUMP: begin
        out_d      = bubble_entry;
        skid_clear = 1'b1;
        fetch_pc_d = jump_target;
        state_d    = FETCH;
        if (bus_req && !bus_done) begin
          state_d = SQUASH;
          if (state_q == FETCH) squash_adr_d = fetch_pc_q;
        end
      end
      STALL: begin
        if (entry_valid) skid_push = 1'b1;
      end
      default: begin
        if (skid_valid) begin
          out_d    = skid_entry;
          skid_pop = 1'b1;
        end else if (entry_valid) begin
          out_d = entry;
        end else begin
          out_d = bubble_entry;
        end
        if (state_q == HOLD) state_d = FETCH;
      end
    endcase

    // A redirect overrides every consequence of a bus response in the same cycle
    if (status_backwards_in != JUMP) begin
      if ((state_q == SQUASH) && bus_done) state_d = FETCH;
      if (ack_fetch) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        if (status_backwards_in == STALL) state_d = HOLD;
      end
      if (entry_valid && (entry.status != VALID)) state_d = HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      fetch_pc_q   <= RESET_ADDRESS;
      squash_adr_q <= RESET_ADDRESS;
      out_q        <= '{instr: NOP, pc: RESET_ADDRESS, status: BUBBLE};
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      squash_adr_q <= squash_adr_d;
      out_q        <= out_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .rst     (rst),
    .clear_i (skid_clear),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .entry_i (entry),
    .valid_o (skid_valid),
    .entry_o (skid_entry)
  );

  assign instruction_reg_out     = out_q.instr;
  assign program_counter_reg_out = out_q.pc;
  assign status_forwards_out     = out_q.status;

endmodule
